// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional build macro: DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } dmem_state_e;

    localparam logic PortCpu = 1'b0;
    localparam logic PortLdr = 1'b1;

    // Wide enough for READ_LATENCY-1 with READ_LATENCY up to 7.
    localparam int unsigned LatW = 3;

    // Loads never write: lane enables only pass through on stores.
    function automatic logic [3:0] lane_we(input logic we, input logic [3:0] be);
        return we ? be : 4'b0000;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_pick.sv
// Combinational winner select between the CPU port and the loader port.
// DMEM_ARB_ROUND_ROBIN_EN defined: the port not granted last wins a tie.
// Undefined: the CPU port always wins a tie.
module dmem_port_arbiter_pick
    import dmem_port_arbiter_pkg::*;
(
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    input  logic last_grant_i,
`endif
    input  logic req0_i,
    input  logic req1_i,
    output logic winner_o
);

    // Pick the winning port; result is a don't-care when nobody requests.
    always_comb begin
        winner_o = PortCpu;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        if (req0_i && req1_i) begin
            winner_o = ~last_grant_i;
        end else if (req1_i) begin
            winner_o = PortLdr;
        end
`else
        if (!req0_i && req1_i) begin
            winner_o = PortLdr;
        end
`endif
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one byte-enabled data memory between the CPU port (0) and the loader port (1).
// One access at a time: issue strobe, fixed read-latency wait, one-cycle ready pulse.
// Optional build macro: DMEM_ARB_ROUND_ROBIN_EN (round-robin instead of fixed priority).
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [3:0]        p0_be_i,
    input  logic [31:0]       p0_wdata_i,
    output logic              p0_ready_o,
    output logic [31:0]       p0_rdata_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [3:0]        p1_be_i,
    input  logic [31:0]       p1_wdata_i,
    output logic              p1_ready_o,
    output logic [31:0]       p1_rdata_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
);

    dmem_state_e       state_q, state_d;
    logic              owner_q, owner_d;
    logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       p0_rdata_q, p1_rdata_q;
    logic              capture;
    logic              winner;

    logic              own_we;
    logic [3:0]        own_be;
    logic [ADDR_W-3:0] own_waddr;
    logic [31:0]       own_wdata;

    // Byte offset is irrelevant to a word-wide memory.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{p0_addr_i[1:0], p1_addr_i[1:0]};

    // Owner's live request fields.
    assign own_we    = owner_q ? p1_we_i : p0_we_i;
    assign own_be    = owner_q ? p1_be_i : p0_be_i;
    assign own_waddr = owner_q ? p1_addr_i[ADDR_W-1:2] : p0_addr_i[ADDR_W-1:2];
    assign own_wdata = owner_q ? p1_wdata_i : p0_wdata_i;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    // Remember the most recently issued port for tie-breaking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= PortLdr;
        end else if (state_q == StIssue) begin
            last_grant_q <= owner_q;
        end
    end

    dmem_port_arbiter_pick u_pick (
        .last_grant_i (last_grant_q),
        .req0_i       (p0_req_i),
        .req1_i       (p1_req_i),
        .winner_o     (winner)
    );
`else
    dmem_port_arbiter_pick u_pick (
        .req0_i   (p0_req_i),
        .req1_i   (p1_req_i),
        .winner_o (winner)
    );
`endif

    // FSM state, owner and latency counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            owner_q   <= PortCpu;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Next-state logic; capture marks the edge into StResp for loads.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        capture   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (p0_req_i || p1_req_i) begin
                    owner_d = winner;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (own_we) begin
                    state_d = StResp;
                end else begin
                    lat_cnt_d = LatW'(READ_LATENCY - 1);
                    if (READ_LATENCY == 1) begin
                        state_d = StResp;
                        capture = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                lat_cnt_d = lat_cnt_q - LatW'(1);
                if (lat_cnt_q == LatW'(1)) begin
                    state_d = StResp;
                    capture = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Hold last issued address/data and per-port load data between accesses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            if (state_q == StIssue) begin
                mem_addr_q  <= own_waddr;
                mem_wdata_q <= own_wdata;
            end
            if (capture && (owner_q == PortCpu)) begin
                p0_rdata_q <= mem_rdata_i;
            end
            if (capture && (owner_q == PortLdr)) begin
                p1_rdata_q <= mem_rdata_i;
            end
        end
    end

    // Outputs: live owner fields during issue, held values otherwise.
    always_comb begin
        mem_en_o    = (state_q == StIssue);
        mem_we_o    = 4'b0000;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = mem_wdata_q;
        if (state_q == StIssue) begin
            mem_we_o    = lane_we(own_we, own_be);
            mem_addr_o  = own_waddr;
            mem_wdata_o = own_wdata;
        end
        p0_ready_o = (state_q == StResp) && (owner_q == PortCpu);
        p1_ready_o = (state_q == StResp) && (owner_q == PortLdr);
        p0_rdata_o = p0_rdata_q;
        p1_rdata_o = p1_rdata_q;
        busy_o     = (state_q != StIdle);
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: instance a uses READ_LATENCY=1, instance b uses 3.
// Honours DMEM_ARB_ROUND_ROBIN_EN for the arbitration expectations.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] mem_rdata_a, mem_rdata_b;

    logic        p0_ready_a, p1_ready_a, mem_en_a, busy_a;
    logic [31:0] p0_rdata_a, p1_rdata_a, mem_wdata_a;
    logic [3:0]  mem_we_a;
    logic [29:0] mem_addr_a;

    logic        p0_ready_b, p1_ready_b, mem_en_b, busy_b;
    logic [31:0] p0_rdata_b, p1_rdata_b, mem_wdata_b;
    logic [3:0]  mem_we_b;
    logic [29:0] mem_addr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .READ_LATENCY(1)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_be_i(p0_be),
        .p0_wdata_i(p0_wdata), .p0_ready_o(p0_ready_a), .p0_rdata_o(p0_rdata_a),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_be_i(p1_be),
        .p1_wdata_i(p1_wdata), .p1_ready_o(p1_ready_a), .p1_rdata_o(p1_rdata_a),
        .mem_en_o(mem_en_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
        .mem_wdata_o(mem_wdata_a), .mem_rdata_i(mem_rdata_a), .busy_o(busy_a)
    );

    dmem_port_arbiter #(.ADDR_W(32), .READ_LATENCY(3)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_be_i(p0_be),
        .p0_wdata_i(p0_wdata), .p0_ready_o(p0_ready_b), .p0_rdata_o(p0_rdata_b),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_be_i(p1_be),
        .p1_wdata_i(p1_wdata), .p1_ready_o(p1_ready_b), .p1_rdata_o(p1_rdata_b),
        .mem_en_o(mem_en_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
        .mem_wdata_o(mem_wdata_b), .mem_rdata_i(mem_rdata_b), .busy_o(busy_b)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [29:0] exp_maddr;
        logic [3:0]  exp_mwe;
        logic [31:0] exp_prdata;
    } vec_t;

    vec_t        vecs [6];
    vec_t        v;
    logic [1:0]  rr_exp [3];
    logic [1:0]  rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
        if (port == 1'b0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_be = be; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_be = be; p1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // port, we, addr, be, wdata, mem_rdata, exp mem_addr, exp mem_we, exp owner rdata
        vecs[0] = '{1'b0, 1'b0, 32'h10,       4'h0, 32'h0,        32'hDEADBEEF,
                    30'h4,        4'h0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h20,       4'h4, 32'h00AB0000, 32'h11111111,
                    30'h8,        4'h4, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'h44,       4'h0, 32'h12345678, 32'h22222222,
                    30'h11,       4'h0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,        32'hCAFEF00D,
                    30'h3FFFFFFF, 4'h0, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b1, 32'h7,        4'hF, 32'hA5A5A5A5, 32'h33333333,
                    30'h1,        4'hF, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b0, 32'h8,        4'h0, 32'h0,        32'h01234567,
                    30'h2,        4'h0, 32'h01234567};
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
`else
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b01; rr_exp[2] = 2'b01;
`endif
        mem_rdata_a = 32'h0;
        mem_rdata_b = 32'h0;

        // Reset state
        do_reset();
        chk("rst_mem_en", mem_en_a, 1'b0);
        chk("rst_mem_we", mem_we_a, 4'h0);
        chk("rst_mem_addr", mem_addr_a, 30'h0);
        chk("rst_mem_wdata", mem_wdata_a, 32'h0);
        chk("rst_ready", {p1_ready_a, p0_ready_a}, 2'b00);
        chk("rst_rdata", {p1_rdata_a, p0_rdata_a}, 64'h0);
        chk("rst_busy", {busy_b, busy_a}, 2'b00);

        // Single transactions on the READ_LATENCY=1 instance
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            mem_rdata_a = v.rdata;
            drive(v.port, 1'b1, v.we, v.addr, v.be, v.wdata);
            step();
            chk($sformatf("v%0d_c1_en", i), mem_en_a, 1'b1);
            chk($sformatf("v%0d_c1_addr", i), mem_addr_a, v.exp_maddr);
            chk($sformatf("v%0d_c1_we", i), mem_we_a, v.exp_mwe);
            chk($sformatf("v%0d_c1_wdata", i), mem_wdata_a, v.wdata);
            chk($sformatf("v%0d_c1_ready", i), {p1_ready_a, p0_ready_a}, 2'b00);
            step();
            chk($sformatf("v%0d_c2_ready", i), {p1_ready_a, p0_ready_a},
                v.port ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_c2_rdata", i), v.port ? p1_rdata_a : p0_rdata_a, v.exp_prdata);
            chk($sformatf("v%0d_c2_en_we", i), {mem_en_a, mem_we_a}, 5'h0);
            drive(v.port, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            step();
            chk($sformatf("v%0d_c3_busy", i), busy_a, 1'b0);
            chk($sformatf("v%0d_c3_hold_addr", i), mem_addr_a, v.exp_maddr);
            chk($sformatf("v%0d_c3_hold_wdata", i), mem_wdata_a, v.wdata);
            chk($sformatf("v%0d_c3_ready", i), {p1_ready_a, p0_ready_a}, 2'b00);
        end

        // Simultaneous loads held for three rounds
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
        for (int r = 0; r < 3; r++) begin
            rdy = 2'b00;
            for (int k = 0; k < 8 && rdy == 2'b00; k++) begin
                step();
                rdy = {p1_ready_a, p0_ready_a};
            end
            chk($sformatf("arb_round%0d", r), rdy, rr_exp[r]);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        step();

        // READ_LATENCY=3: p1 load, p0 raised during the wait
        do_reset();
        mem_rdata_b = 32'hBAD00000;
        drive(1'b1, 1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
        step();
        chk("l3_c1_en", mem_en_b, 1'b1);
        chk("l3_c1_addr", mem_addr_b, 30'hC);
        chk("l3_c1_we", mem_we_b, 4'h0);
        step();
        chk("l3_c2_en", mem_en_b, 1'b0);
        chk("l3_c2_busy", busy_b, 1'b1);
        chk("l3_c2_ready", {p1_ready_b, p0_ready_b}, 2'b00);
        drive(1'b0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        step();
        chk("l3_c3_ready", {p1_ready_b, p0_ready_b}, 2'b00);
        mem_rdata_b = 32'h600DF00D;
        step();
        chk("l3_c4_ready", {p1_ready_b, p0_ready_b}, 2'b10);
        chk("l3_c4_rdata", p1_rdata_b, 32'h600DF00D);
        mem_rdata_b = 32'hBAD00000;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("l3_c5_idle", {busy_b, mem_en_b}, 2'b00);
        step();
        chk("l3_c6_p0_en", mem_en_b, 1'b1);
        chk("l3_c6_p0_addr", mem_addr_b, 30'h10);
        step();
        step();
        step();
        chk("l3_c9_ready", {p1_ready_b, p0_ready_b}, 2'b01);
        chk("l3_c9_rdata", p0_rdata_b, 32'hBAD00000);
        chk("l3_c9_p1_hold", p1_rdata_b, 32'h600DF00D);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();

        // Reset while waiting aborts the access
        drive(1'b0, 1'b1, 1'b0, 32'h50, 4'h0, 32'h0);
        step();
        step();
        chk("abort_c2_busy", busy_b, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("abort_busy", busy_b, 1'b0);
        chk("abort_ready", {p1_ready_b, p0_ready_b}, 2'b00);
        chk("abort_mem", {mem_en_b, mem_we_b, mem_addr_b}, 35'h0);
        chk("abort_wdata", mem_wdata_b, 32'h0);
        chk("abort_rdata", {p1_rdata_b, p0_rdata_b}, 64'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("abort_no_ready%0d", k), {p1_ready_b, p0_ready_b}, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
